// File: rtl/dsm_mix_ctrl.sv
// -----------------------------------------------------------------------------
// dsm_mix_ctrl
//
// Sample scheduler and voice mixer placed in front of a first-order
// delta-sigma modulator.
//
// A down-counter generates the sample-rate strobe. Each voice generator
// hands over at most one sample per period through a valid/ready handshake.
// On every strobe, a single time-shared adder sums the voices, one voice per
// cycle. A voice with no fresh sample contributes its previous sample.
// The average of the voices is then scaled around midscale by a 0..16 gain.
// The gain ramps one step per period, so mute and unmute are click-free.
//
// Ports:
//   clk          clock
//   reset_n      synchronous active-low reset
//   cfg_div      sample period in clk cycles minus 1 (taken at counter reload)
//   mute_req     1 = ramp gain to 0, 0 = ramp gain to 16
//   voice_valid  per-voice sample valid
//   voice_data   voice i in bits [i*DEPTH +: DEPTH], unsigned, midscale-centred
//   voice_ready  per-voice ready (holding register empty)
//   sample_tick  one-cycle strobe at the start of each sample period
//   dsm_enable   modulator enable (low while the gain is 0)
//   dsm_data     modulator input sample
//   muted        gain is 0 and the modulator is frozen
//   overrun      sticky: a strobe arrived while a mix was still running
// -----------------------------------------------------------------------------
module dsm_mix_ctrl #(
    parameter int DEPTH  = 8,
    parameter int NVOICE = 4,
    parameter int DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    mute_req,
    input  logic [NVOICE-1:0]       voice_valid,
    input  logic [NVOICE*DEPTH-1:0] voice_data,
    output logic [NVOICE-1:0]       voice_ready,
    output logic                    sample_tick,
    output logic                    dsm_enable,
    output logic [DEPTH-1:0]        dsm_data,
    output logic                    muted,
    output logic                    overrun
);

    localparam int LOG2N = $clog2(NVOICE);
    localparam int ACC_W = DEPTH + LOG2N;
    localparam int PW    = DEPTH + 7;   // product width: (DEPTH+1)-bit diff times 6-bit gain

    localparam logic [DEPTH-1:0]     MID      = {1'b1, {(DEPTH-1){1'b0}}};
    localparam logic signed [PW-1:0] MID_EXT  = {7'b0, 1'b1, {(DEPTH-1){1'b0}}};
    localparam logic [LOG2N-1:0]     IDX_LAST = '1;
    localparam logic [LOG2N-1:0]     IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]     CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]           GAIN_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX   = 2'd1,
        APPLY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] cnt_reg;
    logic             tick_reg;

    state_t           state_reg;
    logic [LOG2N-1:0] idx_reg;
    logic [ACC_W-1:0] acc_reg;

    logic [NVOICE-1:0] held_reg;
    logic [DEPTH-1:0]  hold_reg [NVOICE];
    logic [DEPTH-1:0]  last_reg [NVOICE];

    logic [4:0]        gain_reg;
    logic [DEPTH-1:0]  dsm_data_reg;
    logic              muted_reg;
    logic              enable_reg;
    logic              overrun_reg;

    // ------------------------------------------------------------------
    // Per-voice unpacking, ready and consume decode
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  voice_sample [NVOICE];
    logic [NVOICE-1:0] consume;

    generate
        for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
            assign voice_sample[gi] = voice_data[gi*DEPTH +: DEPTH];
            assign voice_ready[gi]  = ~held_reg[gi];
            // The slot being mixed this cycle gives up its held sample.
            assign consume[gi]      = (state_reg == MIX) && (idx_reg == LOG2N'(gi))
                                      && held_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sample-period down-counter. cfg_div is only looked at on reload, so a
    // new period length starts cleanly at the next period boundary.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == '0) begin
            cnt_reg  <= cfg_div;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg - CNT_ONE;
            tick_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Voice holding registers. A held sample moves to last_reg when it is
    // mixed, so a voice that misses a period repeats its previous sample.
    // Load and consume never coincide: a load needs held=0, a consume needs
    // held=1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_reg <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                hold_reg[i] <= '0;
                last_reg[i] <= MID;
            end
        end else begin
            for (int i = 0; i < NVOICE; i++) begin
                if (consume[i]) begin
                    held_reg[i] <= 1'b0;
                    last_reg[i] <= hold_reg[i];
                end else if (voice_valid[i] && !held_reg[i]) begin
                    hold_reg[i] <= voice_sample[i];
                    held_reg[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mix datapath
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] add_val;
    assign add_val = held_reg[idx_reg] ? hold_reg[idx_reg] : last_reg[idx_reg];

    // The average is truncated. It is recentred around zero so that the
    // gain scales the deviation from midscale rather than the raw code.
    logic [DEPTH-1:0]         mix_val;
    logic signed [DEPTH:0]    diff;
    logic signed [PW-1:0]     diff_ext;
    logic signed [PW-1:0]     gain_ext;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic signed [PW-1:0]     out_full;
    logic [DEPTH-1:0]         dsm_data_next;
    logic [4:0]               gain_next;

    assign mix_val       = acc_reg[ACC_W-1:LOG2N];
    assign diff          = $signed({1'b0, mix_val}) - $signed({1'b0, MID});
    assign diff_ext      = {{6{diff[DEPTH]}}, diff};
    assign gain_ext      = {{(DEPTH+2){1'b0}}, gain_reg};
    assign prod          = diff_ext * gain_ext;
    assign scaled        = prod >>> 4;
    // |scaled| <= |diff|, so midscale + scaled always fits in DEPTH bits.
    assign out_full      = MID_EXT + scaled;
    assign dsm_data_next = out_full[DEPTH-1:0];

    always_comb begin
        gain_next = gain_reg;
        if (mute_req) begin
            if (gain_reg != 5'd0) begin
                gain_next = gain_reg - 5'd1;
            end
        end else begin
            if (gain_reg != GAIN_MAX) begin
                gain_next = gain_reg + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            acc_reg      <= '0;
            gain_reg     <= '0;
            dsm_data_reg <= MID;
            muted_reg    <= 1'b1;
            enable_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            // A strobe that lands on a running mix is dropped. The mix in
            // progress finishes untouched.
            if (tick_reg && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (tick_reg) begin
                        state_reg <= MIX;
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                    end
                end
                MIX: begin
                    acc_reg <= acc_reg + {{LOG2N{1'b0}}, add_val};
                    idx_reg <= idx_reg + IDX_ONE;
                    if (idx_reg == IDX_LAST) begin
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    // The output uses the gain of this period. The gain then
                    // steps once toward its target.
                    dsm_data_reg <= dsm_data_next;
                    gain_reg     <= gain_next;
                    muted_reg    <= (gain_next == 5'd0);
                    enable_reg   <= (gain_next != 5'd0);
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sample_tick = tick_reg;
    assign dsm_enable  = enable_reg;
    assign dsm_data    = dsm_data_reg;
    assign muted       = muted_reg;
    assign overrun     = overrun_reg;

endmodule
